// File: rtl/data_ram_hs.sv
// data_ram_hs : byte-addressed big-endian data memory with a 4-phase
// MFA/MFC handshake and programmable wait states.
//
// Ports
//   clk      in   sole clock, all state on rising edge
//   clr      in   synchronous active-high reset (memory contents survive)
//   mfa      in   memory function activate (request)
//   rw       in   1 = read, 0 = write
//   mas      in   access size: 00 byte, 01 halfword, 10 word, 11 reserved
//   addr     in   byte address
//   data_in  in   write data; byte in [7:0], halfword in [15:0]
//   data_out out  registered read data, zero-extended
//   mfc      out  memory function complete
//   err      out  access fault flag, valid while mfc=1
module data_ram_hs #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              mfa,
   input  logic              rw,
   input  logic [1:0]        mas,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       data_in,
   output logic [31:0]       data_out,
   output logic              mfc,
   output logic              err
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              rw_q;
   logic [1:0]        mas_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              mfc_q, mfc_d;
   logic              err_q, err_d;
   logic [31:0]       dout_q, dout_d;

   logic [7:0]        mem [2**ADDR_W];
   logic [7:0]        rbyte [4];
   logic [7:0]        wbyte [4];
   logic [3:0]        we;
   logic              req_load;
   logic              access;
   logic              fault;

   // State register plus request/output registers
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rw_q    <= 1'b0;
         mas_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         mfc_q   <= 1'b0;
         err_q   <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mfc_q   <= mfc_d;
         err_q   <= err_d;
         dout_q  <= dout_d;
         if (req_load) begin
            rw_q    <= rw;
            mas_q   <= mas;
            addr_q  <= addr;
            wdata_q <= data_in;
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (mfa) begin
               if (WAIT_CYCLES > 0) begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_INIT;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) state_d = S_DONE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_DONE: begin
            if (mfc_q && !mfa) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output / datapath logic.
   // DONE is entered one edge before the access; the access edge is the
   // first DONE edge (mfc_q still 0), which keeps mfc latency at
   // WAIT_CYCLES+1 for every WAIT_CYCLES including 0.
   always_comb begin
      req_load = (state_q == S_IDLE) && mfa;
      access   = (state_q == S_DONE) && !mfc_q;
      fault    = (mas_q == 2'b11) ||
                 ((mas_q == 2'b01) && addr_q[0]) ||
                 ((mas_q == 2'b10) && (addr_q[1:0] != 2'b00));

      for (int unsigned k = 0; k < 4; k++) begin
         rbyte[k] = mem[addr_q + ADDR_W'(k)];
         wbyte[k] = '0;
      end

      we     = '0;
      mfc_d  = mfc_q;
      err_d  = err_q;
      dout_d = dout_q;

      if (access) begin
         mfc_d = 1'b1;
         err_d = fault;
         if (fault) begin
            dout_d = '0;
         end else if (rw_q) begin
            unique case (mas_q)
               2'b00:   dout_d = {24'd0, rbyte[0]};
               2'b01:   dout_d = {16'd0, rbyte[0], rbyte[1]};
               default: dout_d = {rbyte[0], rbyte[1], rbyte[2], rbyte[3]};
            endcase
         end else begin
            // Big-endian: lowest address holds the most significant byte
            unique case (mas_q)
               2'b00: begin
                  we       = 4'b0001;
                  wbyte[0] = wdata_q[7:0];
               end
               2'b01: begin
                  we       = 4'b0011;
                  wbyte[0] = wdata_q[15:8];
                  wbyte[1] = wdata_q[7:0];
               end
               default: begin
                  we       = 4'b1111;
                  wbyte[0] = wdata_q[31:24];
                  wbyte[1] = wdata_q[23:16];
                  wbyte[2] = wdata_q[15:8];
                  wbyte[3] = wdata_q[7:0];
               end
            endcase
         end
      end else if ((state_q == S_DONE) && mfc_q && !mfa) begin
         mfc_d = 1'b0;
         err_d = 1'b0;
      end
   end

   // Memory array: no reset; a clr on the access edge suppresses the write
   always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < 4; k++) begin
         if (we[k] && !clr) mem[addr_q + ADDR_W'(k)] <= wbyte[k];
      end
   end

   assign data_out = dout_q;
   assign mfc      = mfc_q;
   assign err      = err_q;

endmodule

// File: tb/tb_data_ram_hs.sv
module tb_data_ram_hs;

   localparam int unsigned AW = 8;
   localparam int unsigned WC = 2;

   logic          clk = 1'b0;
   logic          clr = 1'b1;
   logic          mfa = 1'b0;
   logic          mfa0 = 1'b0;
   logic          rw = 1'b0;
   logic [1:0]    mas = '0;
   logic [AW-1:0] addr = '0;
   logic [31:0]   data_in = '0;
   logic [31:0]   data_out, data_out0;
   logic          mfc, err, mfc0, err0;

   always #5 clk = ~clk;

   data_ram_hs #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
      .clk(clk), .clr(clr), .mfa(mfa), .rw(rw), .mas(mas), .addr(addr),
      .data_in(data_in), .data_out(data_out), .mfc(mfc), .err(err)
   );

   data_ram_hs #(.ADDR_W(AW), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .clr(clr), .mfa(mfa0), .rw(rw), .mas(mas), .addr(addr),
      .data_in(data_in), .data_out(data_out0), .mfc(mfc0), .err(err0)
   );

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int unsigned n_cmp = 0;
   int unsigned n_fail = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: byte-addressed memory and the last data_out value
   logic [7:0]  mm [2**AW];
   logic [31:0] dout_m = '0;

   typedef struct {
      logic [31:0] dout;
      logic        err;
      int unsigned due;
      string       name;
   } exp_t;
   exp_t sbq[$];

   // Monitor: every rising mfc must match the oldest outstanding expectation
   exp_t mon_e;
   logic mfc_prev = 1'b0;
   always @(negedge clk) begin
      if (mfc === 1'b1 && mfc_prev !== 1'b1) begin
         if (sbq.size() == 0) begin
            check("unexpected_mfc", 32'd1, 32'd0);
         end else begin
            mon_e = sbq.pop_front();
            check({mon_e.name, "_dout"}, data_out, mon_e.dout);
            check({mon_e.name, "_err"}, {31'd0, err}, {31'd0, mon_e.err});
            check({mon_e.name, "_lat"}, cyc, mon_e.due);
         end
      end
      mfc_prev = mfc;
   end

   // One full transaction on the WC-wait DUT. clr_cyc>0 first holds clr
   // high with mfa already high; hold keeps mfa high after mfc rises.
   task automatic txn(input string nm, input logic r, input logic [1:0] s,
                      input logic [AW-1:0] a, input logic [31:0] d,
                      input int unsigned hold, input int unsigned clr_cyc);
      exp_t e;
      bit   flt;
      int   nb;
      flt = (s == 2'b11) || (s == 2'b01 && a % 2 != 0) || (s == 2'b10 && a % 4 != 0);
      nb  = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
      @(negedge clk);
      rw = r; mas = s; addr = a; data_in = d; mfa = 1'b1;
      if (clr_cyc > 0) begin
         clr = 1'b1;
         repeat (clr_cyc) begin
            @(negedge clk);
            check({nm, "_clr_mfc"}, {31'd0, mfc}, 32'd0);
         end
         check({nm, "_clr_dout"}, data_out, 32'd0);
         clr = 1'b0;
         dout_m = '0;
      end
      if (flt) begin
         dout_m = '0;
      end else if (r) begin
         dout_m = '0;
         for (int k = 0; k < nb; k++) dout_m = {dout_m[23:0], mm[int'(a) + k]};
      end else begin
         for (int k = 0; k < nb; k++) mm[int'(a) + k] = 8'(d >> (8 * (nb - 1 - k)));
      end
      e.dout = dout_m; e.err = flt; e.name = nm;
      e.due  = cyc + 1 + WC + 1;
      sbq.push_back(e);
      @(negedge clk);
      // Request is latched; input changes must now be ignored
      rw = 1'($urandom); mas = 2'($urandom); addr = AW'($urandom); data_in = $urandom;
      for (int i = 0; i < 20 && mfc !== 1'b1; i++) @(negedge clk);
      check({nm, "_mfc_up"}, {31'd0, mfc}, 32'd1);
      repeat (hold) begin
         @(negedge clk);
         check({nm, "_hold"}, {31'd0, mfc}, 32'd1);
      end
      mfa = 1'b0;
      @(negedge clk);
      check({nm, "_mfc_down"}, {31'd0, mfc}, 32'd0);
      check({nm, "_err_down"}, {31'd0, err}, 32'd0);
   endtask

   // Zero-wait DUT: latency and data only
   task automatic txn0(input string nm, input logic r, input logic [1:0] s,
                       input logic [AW-1:0] a, input logic [31:0] d, input logic [31:0] exp_d);
      int unsigned iss;
      @(negedge clk);
      rw = r; mas = s; addr = a; data_in = d; mfa0 = 1'b1;
      iss = cyc + 1;
      @(negedge clk);
      for (int i = 0; i < 10 && mfc0 !== 1'b1; i++) @(negedge clk);
      check({nm, "_lat"}, cyc, iss + 1);
      check({nm, "_dout"}, data_out0, exp_d);
      mfa0 = 1'b0;
      @(negedge clk);
      check({nm, "_down"}, {31'd0, mfc0}, 32'd0);
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_dout", data_out, 32'd0);
      check("rst_mfc", {31'd0, mfc}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_mfc0", {31'd0, mfc0}, 32'd0);
      clr = 1'b0;

      // Word write then word/byte reads
      txn("w10",  1'b0, 2'b10, 8'h10, 32'h11223344, 0, 0);
      txn("rw10", 1'b1, 2'b10, 8'h10, 32'h0, 0, 0);
      txn("rb10", 1'b1, 2'b00, 8'h10, 32'h0, 0, 0);
      txn("rb13", 1'b1, 2'b00, 8'h13, 32'h0, 0, 0);
      txn("rh12", 1'b1, 2'b01, 8'h12, 32'h0, 0, 0);

      // Partial writes
      txn("w20",  1'b0, 2'b10, 8'h20, 32'hAABBCCDD, 0, 0);
      txn("wh22", 1'b0, 2'b01, 8'h22, 32'hFFFF1234, 0, 0);
      txn("wb20", 1'b0, 2'b00, 8'h20, 32'hFFFFFF55, 0, 0);
      txn("rw20", 1'b1, 2'b10, 8'h20, 32'h0, 0, 0);

      // Faults
      txn("fh21", 1'b1, 2'b01, 8'h21, 32'h0, 0, 0);
      txn("rw10b", 1'b1, 2'b10, 8'h10, 32'h0, 0, 0);
      txn("fw22", 1'b0, 2'b10, 8'h22, 32'h99999999, 0, 0);
      txn("fm3r", 1'b1, 2'b11, 8'h20, 32'h0, 0, 0);
      txn("fm3w", 1'b0, 2'b11, 8'h20, 32'h77777777, 0, 0);
      txn("rw20b", 1'b1, 2'b10, 8'h20, 32'h0, 0, 0);

      // Extended handshake hold: one transaction only
      txn("hold40", 1'b0, 2'b10, 8'h40, 32'h0F1E2D3C, 10, 0);
      txn("rw40",   1'b1, 2'b10, 8'h40, 32'h0, 0, 0);

      // Reset abort at WAIT, WAIT(last), and the access edge itself
      txn("w30", 1'b0, 2'b10, 8'h30, 32'hCAFEF00D, 0, 0);
      for (int d = 1; d <= 3; d++) begin
         @(negedge clk);
         rw = 1'b0; mas = 2'b10; addr = 8'h30; data_in = 32'hDEADBEEF; mfa = 1'b1;
         repeat (d) @(negedge clk);
         clr = 1'b1; mfa = 1'b0;
         @(negedge clk);
         clr = 1'b0;
         dout_m = '0;
         check("abort_dout", data_out, 32'd0);
         repeat (6) begin
            @(negedge clk);
            check("abort_mfc", {31'd0, mfc}, 32'd0);
         end
         txn("abort_rd30", 1'b1, 2'b10, 8'h30, 32'h0, 0, 0);
      end

      // clr with mfa high, then start on release
      txn("clr_mfa_rd10", 1'b1, 2'b10, 8'h10, 32'h0, 0, 3);

      // Zero-wait-state instance
      txn0("z_w10",  1'b0, 2'b10, 8'h10, 32'h0BADCAFE, 32'h0);
      txn0("z_rw10", 1'b1, 2'b10, 8'h10, 32'h0, 32'h0BADCAFE);
      txn0("z_rb11", 1'b1, 2'b00, 8'h11, 32'h0, 32'h000000AD);

      // Randomized: initialise a region, then mixed accesses within it
      for (int i = 0; i < 16; i++)
         txn("rnd_fill", 1'b0, 2'b10, AW'(8'h80 + 4 * i), $urandom, 0, 0);
      for (int i = 0; i < 60; i++)
         txn("rnd", 1'($urandom), 2'($urandom), AW'(8'h80 + $urandom_range(0, 63)),
             $urandom, $urandom_range(0, 2), 0);

      repeat (4) @(negedge clk);
      check("sb_empty", sbq.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
